polyz_pack_ctrl: RTL and testbench

Sequencer that packs the Dilithium response vector z (L polynomials, 256 coefficients each) through one shared combinational polyz_pack instance. It runs one polynomial at a time:
- fetches coefficients from a coefficient RAM into the 8192-bit pack input register;
- captures the 5120-bit packed result;
- streams the 640 bytes per polynomial out on a valid/ready byte interface toward the signature buffer.

---
 rtl/polyz_pack_ctrl.sv | 159 +++++++++++++++
 tb/tb_polyz_pack_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polyz_pack_ctrl.sv
// polyz_pack_ctrl: sequences the L polynomials of z through one shared
// combinational polyz_pack. For each polynomial it loads 256 coefficients
// from RAM into pack_a, captures the 640 packed bytes, and streams them out
// over a valid/ready byte interface before moving to the next polynomial.
module polyz_pack_ctrl #(
  parameter int L      = 4,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic [8191:0]     pack_a,
  input  logic [5119:0]     pack_r,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_poly_last,
  output logic              out_last
);

  // Upper address bits select the polynomial, lower 8 bits the coefficient.
  localparam int PW = ADDR_W - 8;
  localparam logic [PW-1:0] LAST_POLY = PW'(L - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    STREAM  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t         state_reg;
  logic [PW-1:0]  poly_reg;     // polynomial currently being processed
  logic [7:0]     idx_reg;      // coefficient index of the next RAM request
  logic           wr_vld_reg;   // RAM data is valid this cycle
  logic [7:0]     wr_idx_reg;   // pack_a slot that the current RAM data belongs to
  logic [9:0]     bcnt_reg;     // byte index within the current polynomial
  logic [5119:0]  byte_buf_reg; // captured pack_r, shifted down one byte per handshake

  // The request address is built directly from the counters, so it is 0 in
  // reset and walks poly*256 + 0..255 while mem_rd_en is high.
  assign mem_rd_addr = {poly_reg, idx_reg};

  // Load datapath: RAM data returns one cycle after its request and lands in
  // the slot recorded when that request was issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_reg <= 1'b0;
      wr_idx_reg <= '0;
      pack_a     <= '0;
    end else begin
      wr_vld_reg <= mem_rd_en;
      wr_idx_reg <= idx_reg;
      if (wr_vld_reg) begin
        pack_a[{wr_idx_reg, 5'd0} +: 32] <= mem_rd_data;
      end
    end
  end

  // Main sequencer: state transitions, read requests, capture and byte streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      poly_reg      <= '0;
      idx_reg       <= '0;
      bcnt_reg      <= '0;
      byte_buf_reg  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_rd_en     <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_poly_last <= 1'b0;
      out_last      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_reg <= LOAD;
            poly_reg  <= '0;
            idx_reg   <= '0;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
          end
        end

        LOAD: begin
          // Issue 256 requests; the index wraps back to 0 after the last one.
          if (mem_rd_en) begin
            idx_reg <= idx_reg + 8'd1;
            if (idx_reg == 8'd255) begin
              mem_rd_en <= 1'b0;
            end
          end
          // Leave once the final coefficient has been written into pack_a.
          if (wr_vld_reg && (wr_idx_reg == 8'd255)) begin
            state_reg <= CAPTURE;
          end
        end

        CAPTURE: begin
          // pack_a has been stable for a full cycle, so pack_r is settled.
          byte_buf_reg  <= pack_r;
          bcnt_reg      <= '0;
          out_valid     <= 1'b1;
          out_data      <= pack_r[7:0];
          out_poly_last <= 1'b0;
          out_last      <= 1'b0;
          state_reg     <= STREAM;
        end

        STREAM: begin
          if (out_valid && out_ready) begin
            if (bcnt_reg == 10'd639) begin
              out_valid     <= 1'b0;
              out_data      <= '0;
              out_poly_last <= 1'b0;
              out_last      <= 1'b0;
              bcnt_reg      <= '0;
              if (poly_reg != LAST_POLY) begin
                // Next polynomial: idx_reg is already back at 0.
                poly_reg  <= poly_reg + 1'b1;
                mem_rd_en <= 1'b1;
                state_reg <= LOAD;
              end else begin
                busy      <= 1'b0;
                done      <= 1'b1;
                state_reg <= DONE;
              end
            end else begin
              bcnt_reg      <= bcnt_reg + 10'd1;
              byte_buf_reg  <= byte_buf_reg >> 8;
              out_data      <= byte_buf_reg[15:8];
              out_poly_last <= (bcnt_reg == 10'd638);
              out_last      <= (bcnt_reg == 10'd638) && (poly_reg == LAST_POLY);
            end
          end
        end

        DONE: begin
          done      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_polyz_pack_ctrl.sv
// tb_polyz_pack_ctrl: directed bench for polyz_pack_ctrl with a behavioural
// coefficient RAM and a behavioural polyz_pack (t = 2^19 - a, 20-bit fields
// packed little-endian).
module tb_polyz_pack_ctrl;

  localparam int L      = 4;
  localparam int ADDR_W = 11;
  localparam int NBYTES = 640 * L;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data = 32'd0;
  logic [8191:0]     pack_a;
  logic [5119:0]     pack_r;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        out_data;
  logic              out_poly_last;
  logic              out_last;

  logic [31:0] ram [0:(1<<ADDR_W)-1];
  logic [31:0] tc;

  int n_checks = 0;
  int n_errors = 0;
  int bcount   = 0;
  int done_cnt = 0;
  int exp_addr = 0;
  logic bp_en  = 1'b0;

  logic [7:0] first_bytes [0:9];
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data;
  logic       stall_pl;
  logic       stall_l;

  polyz_pack_ctrl #(.L(L), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .pack_a        (pack_a),
    .pack_r        (pack_r),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_poly_last (out_poly_last),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  // Coefficient RAM: data valid exactly one cycle after the request, junk otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    else           mem_rd_data <= 32'hDEADBEEF;
  end

  // Behavioural polyz_pack: coefficient c occupies bits [20c+19:20c].
  always_comb begin
    pack_r = '0;
    tc     = '0;
    for (int c = 0; c < 256; c++) begin
      tc = 32'h80000 - pack_a[32*c +: 32];
      pack_r[20*c +: 20] = tc[19:0];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference byte n of the whole response, from the current RAM contents.
  function automatic logic [7:0] exp_byte(input int n);
    int p, j, g, b;
    logic [79:0] grp;
    logic [31:0] t;
    p = n / 640; j = n % 640; g = j / 10; b = j % 10;
    grp = '0;
    for (int k = 0; k < 4; k++) begin
      t = 32'h80000 - ram[p*256 + 4*g + k];
      grp[20*k +: 20] = t[19:0];
    end
    return grp[8*b +: 8];
  endfunction

  // Ready driver: always high, or about 40% low under backpressure.
  initial forever begin
    @(posedge clk); #1;
    out_ready = bp_en ? ($urandom_range(0, 99) >= 40) : 1'b1;
  end

  // Monitor: read address sequence, byte stream, stall stability, done pulses.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (mem_rd_en) begin
        chk("rd_addr", 64'(mem_rd_addr), 64'(exp_addr));
        exp_addr++;
      end
      if (done) done_cnt++;
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(stall_data));
        chk("hold_poly_last", 64'(out_poly_last), 64'(stall_pl));
        chk("hold_last", 64'(out_last), 64'(stall_l));
      end
      if (out_valid && out_ready) begin
        if (bcount < NBYTES) begin
          chk("byte", 64'(out_data), 64'(exp_byte(bcount)));
          chk("poly_last", 64'(out_poly_last), 64'((bcount % 640) == 639));
          chk("last", 64'(out_last), 64'(bcount == NBYTES - 1));
          if (bcount < 10) first_bytes[bcount] = out_data;
        end else begin
          chk("extra_byte", 64'(bcount), 64'(NBYTES - 1));
        end
        bcount++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_pl   = out_poly_last;
      stall_l    = out_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_run();
    bcount = 0; done_cnt = 0; exp_addr = 0;
  endtask

  task automatic fill_zero();
    for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = 32'd0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = $urandom();
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      tick(1);
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    tick(1);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [7:0] ref10 [0:9];
    ref10 = '{8'h00, 8'h00, 8'hD8, 8'h04, 8'h80, 8'h0A, 8'hFF, 8'h77, 8'h0E, 8'h80};

    // Reset state
    fill_zero();
    tick(3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_last", 64'({out_poly_last, out_last}), 64'd0);
    chk("rst_pack_a", 64'(|pack_a), 64'd0);
    rst = 1'b0;
    tick(2);

    // Scenario 1: all-zero RAM, ready tied high, latency and done timing
    clear_run();
    pulse_start();
    chk("s1_busy_c1", 64'(busy), 64'd1);
    chk("s1_rd_en_c1", 64'(mem_rd_en), 64'd1);
    cyc = 1;
    while (!done && cyc < 6000) begin
      tick(1);
      cyc++;
      if (cyc == 256) chk("s1_rd_en_c256", 64'(mem_rd_en), 64'd1);
      if (cyc == 257) chk("s1_rd_en_c257", 64'(mem_rd_en), 64'd0);
      if (cyc == 258) chk("s1_valid_c258", 64'(out_valid), 64'd0);
      if (cyc == 259) chk("s1_valid_c259", 64'(out_valid), 64'd1);
      if (cyc == 3592) chk("s1_busy_c3592", 64'(busy), 64'd1);
    end
    chk("s1_done_cycle", 64'(cyc), 64'(4*898 + 1));
    chk("s1_busy_at_done", 64'(busy), 64'd0);
    tick(1);
    chk("s1_done_pulse", 64'(done), 64'd0);
    chk("s1_bytes", 64'(bcount), 64'(NBYTES));
    chk("s1_done_cnt", 64'(done_cnt), 64'd1);
    chk("s1_reads", 64'(exp_addr), 64'(256*L));
    tick(2);

    // Scenario 2: known coefficient vector in poly 0, slot contents at CAPTURE
    fill_rand();
    ram[0] = 32'd0; ram[1] = -32'sd77; ram[2] = 32'd246; ram[3] = -32'sd231;
    clear_run();
    pulse_start();
    tick(257);
    chk("s2_capture_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 256; i++) chk("s2_slot", 64'(pack_a[32*i +: 32]), 64'(ram[i]));
    wait_done(6000, cyc);
    for (int i = 0; i < 10; i++) chk("s2_first_bytes", 64'(first_bytes[i]), 64'(ref10[i]));
    chk("s2_bytes", 64'(bcount), 64'(NBYTES));
    chk("s2_done_cnt", 64'(done_cnt), 64'd1);
    tick(2);

    // Scenarios 3 and 5: backpressure, start pulses during LOAD and STREAM
    fill_rand();
    clear_run();
    bp_en = 1'b1;
    pulse_start();
    tick(100);
    pulse_start();
    chk("s5_busy_after_load_start", 64'(busy), 64'd1);
    cyc = 0;
    while (!out_valid && cyc < 1000) begin tick(1); cyc++; end
    chk("s5_reached_stream", 64'(out_valid), 64'd1);
    tick(20);
    pulse_start();
    wait_done(20000, cyc);
    chk("s3_bytes", 64'(bcount), 64'(NBYTES));
    chk("s3_reads", 64'(exp_addr), 64'(256*L));
    tick(50);
    chk("s5_idle_busy", 64'(busy), 64'd0);
    chk("s5_done_cnt", 64'(done_cnt), 64'd1);
    bp_en = 1'b0;
    tick(2);

    // Scenario 6: reset at byte 300 of poly 1, then a clean restart
    clear_run();
    pulse_start();
    cyc = 0;
    while (bcount < 640 + 300 && cyc < 3000) begin tick(1); cyc++; end
    chk("s6_reached_byte", 64'(bcount >= 940), 64'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("s6_valid", 64'(out_valid), 64'd0);
    chk("s6_busy", 64'(busy), 64'd0);
    chk("s6_rd_en", 64'(mem_rd_en), 64'd0);
    chk("s6_data", 64'(out_data), 64'd0);
    chk("s6_lasts", 64'({out_poly_last, out_last}), 64'd0);
    chk("s6_pack_a", 64'(|pack_a), 64'd0);
    tick(1200);
    chk("s6_no_done", 64'(done_cnt), 64'd0);
    chk("s6_idle_busy", 64'(busy), 64'd0);
    fill_zero();
    clear_run();
    pulse_start();
    wait_done(6000, cyc);
    chk("s6_restart_bytes", 64'(bcount), 64'(NBYTES));
    chk("s6_restart_done_cnt", 64'(done_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
